// File: rtl/avalon_st_fifo.sv
// avalon_st_fifo: elastic beat FIFO between avalon_enforcer and an Avalon-ST sink.
// Define AVALON_FIFO_PKT_STATS_EN to add saturating packet/byte counters on the output side.
module avalon_st_fifo #(
    parameter int unsigned DATA_WIDTH_IN_BYTES = 16,
    parameter int unsigned DEPTH               = 8,
    parameter int unsigned ALMOST_FULL_LVL     = 6
) (
    input  logic                                   clk,
    input  logic                                   rst,
    // upstream (slave) stream
    input  logic                                   i_in_valid,
    output logic                                   o_in_rdy,
    input  logic [DATA_WIDTH_IN_BYTES*8-1:0]       i_in_data,
    input  logic                                   i_in_sop,
    input  logic                                   i_in_eop,
    input  logic [$clog2(DATA_WIDTH_IN_BYTES)-1:0] i_in_empty,
    // downstream (master) stream
    output logic                                   o_out_valid,
    input  logic                                   i_out_rdy,
    output logic [DATA_WIDTH_IN_BYTES*8-1:0]       o_out_data,
    output logic                                   o_out_sop,
    output logic                                   o_out_eop,
    output logic [$clog2(DATA_WIDTH_IN_BYTES)-1:0] o_out_empty,
    // status
    output logic [$clog2(DEPTH):0]                 o_fill_level,
    output logic                                   o_almost_full
`ifdef AVALON_FIFO_PKT_STATS_EN
    ,
    output logic [31:0]                            o_pkt_cnt,
    output logic [31:0]                            o_byte_cnt
`endif
);

    localparam int unsigned DATA_W  = DATA_WIDTH_IN_BYTES * 8;
    localparam int unsigned EMPTY_W = $clog2(DATA_WIDTH_IN_BYTES);
    localparam int unsigned IDX_W   = $clog2(DEPTH);
    localparam int unsigned PTR_W   = IDX_W + 1;

    logic [DATA_W-1:0]  r_mem_data  [DEPTH];
    logic [EMPTY_W-1:0] r_mem_empty [DEPTH];
    logic [DEPTH-1:0]   r_mem_sop;
    logic [DEPTH-1:0]   r_mem_eop;

    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_fill;
    logic               r_in_rdy;
    logic               r_out_valid;
    logic               r_almost_full;

    logic               w_wr;
    logic               w_rd;
    logic [PTR_W-1:0]   w_wr_ptr_next;
    logic [PTR_W-1:0]   w_rd_ptr_next;
    logic [PTR_W-1:0]   w_fill_next;
    logic [IDX_W-1:0]   w_wr_idx;
    logic [IDX_W-1:0]   w_rd_idx;

    assign w_wr     = i_in_valid && r_in_rdy;
    assign w_rd     = r_out_valid && i_out_rdy;
    assign w_wr_idx = r_wr_ptr[IDX_W-1:0];
    assign w_rd_idx = r_rd_ptr[IDX_W-1:0];

    // Pointer MSB separates full from empty, so the level is a plain difference.
    always_comb begin
        w_wr_ptr_next = r_wr_ptr;
        w_rd_ptr_next = r_rd_ptr;
        if (w_wr) w_wr_ptr_next = r_wr_ptr + PTR_W'(1);
        if (w_rd) w_rd_ptr_next = r_rd_ptr + PTR_W'(1);
        w_fill_next = w_wr_ptr_next - w_rd_ptr_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_fill        <= '0;
            r_in_rdy      <= 1'b0;
            r_out_valid   <= 1'b0;
            r_almost_full <= 1'b0;
        end else begin
            r_wr_ptr      <= w_wr_ptr_next;
            r_rd_ptr      <= w_rd_ptr_next;
            r_fill        <= w_fill_next;
            r_in_rdy      <= (w_fill_next < PTR_W'(DEPTH));
            r_out_valid   <= (w_fill_next != '0);
            r_almost_full <= (w_fill_next >= PTR_W'(ALMOST_FULL_LVL));
        end
    end

    // Storage needs no reset: entries are only observed behind out.valid.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem_data[w_wr_idx]  <= i_in_data;
            r_mem_empty[w_wr_idx] <= i_in_empty;
            r_mem_sop[w_wr_idx]   <= i_in_sop;
            r_mem_eop[w_wr_idx]   <= i_in_eop;
        end
    end

    assign o_in_rdy      = r_in_rdy;
    assign o_out_valid   = r_out_valid;
    assign o_out_data    = r_mem_data[w_rd_idx];
    assign o_out_empty   = r_mem_empty[w_rd_idx];
    assign o_out_sop     = r_mem_sop[w_rd_idx] & r_out_valid;
    assign o_out_eop     = r_mem_eop[w_rd_idx] & r_out_valid;
    assign o_fill_level  = r_fill;
    assign o_almost_full = r_almost_full;

`ifdef AVALON_FIFO_PKT_STATS_EN
    logic [31:0] r_pkt_cnt;
    logic [31:0] r_byte_cnt;
    logic [31:0] w_beat_bytes;
    logic [32:0] w_byte_sum;

    // Valid bytes of the head beat; the 33rd sum bit flags saturation.
    always_comb begin
        w_beat_bytes = 32'(DATA_WIDTH_IN_BYTES);
        if (o_out_eop) w_beat_bytes = 32'(DATA_WIDTH_IN_BYTES) - 32'(o_out_empty);
        w_byte_sum = {1'b0, r_byte_cnt} + {1'b0, w_beat_bytes};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pkt_cnt  <= '0;
            r_byte_cnt <= '0;
        end else if (w_rd) begin
            if (o_out_eop && (r_pkt_cnt != 32'hFFFF_FFFF)) r_pkt_cnt <= r_pkt_cnt + 32'd1;
            r_byte_cnt <= w_byte_sum[32] ? 32'hFFFF_FFFF : w_byte_sum[31:0];
        end
    end

    assign o_pkt_cnt  = r_pkt_cnt;
    assign o_byte_cnt = r_byte_cnt;
`endif

endmodule
